rab_inv_range_ctrl: RTL and testbench

- Receives range-invalidate commands on the RAB AXI-Lite config write path and answers each one with a B response.
- A command is a write of the low VA to 0x10, then a write of the high VA to 0x18; the 0x18 write triggers the sweep.
- One cycle clears every overlapping L1 slice; a sequential sweep then clears every overlapping L2 TLB entry.
- Sits between the config AXI-Lite write demux and the L1 slice valid bits / L2 TLB RAM port.

---
 rtl/rab_inv_range_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rab_inv_range_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rab_inv_range_ctrl.sv
// RAB range-invalidate controller: AXI-Lite Lo/Hi capture, single-cycle L1 clear, sequential L2 sweep.
// Optional RAB_INV_HIT_CNT_EN adds a saturating InvCnt_DO count of issued clears.
module rab_inv_range_ctrl #(
   parameter int unsigned AW               = 32,
   parameter int unsigned N_SLICES         = 16,
   parameter int unsigned L2_N_SETS        = 32,
   parameter int unsigned L2_N_SET_ENTRIES = 32,
   parameter int unsigned PG_BITS          = 12
) (
   input  logic                                              Clk_CI,
   input  logic                                              Rst_RI,
   input  logic [AW-1:0]                                     AwAddr_DI,
   input  logic                                              AwValid_SI,
   output logic                                              AwReady_SO,
   input  logic [AW-1:0]                                     WData_DI,
   input  logic                                              WValid_SI,
   output logic                                              WReady_SO,
   output logic [1:0]                                        BResp_DO,
   output logic                                              BValid_SO,
   input  logic                                              BReady_SI,
   input  logic [N_SLICES*AW-1:0]                            L1First_DI,
   input  logic [N_SLICES*AW-1:0]                            L1Last_DI,
   output logic [N_SLICES-1:0]                               L1Inv_SO,
   output logic [$clog2(L2_N_SETS*L2_N_SET_ENTRIES)-1:0]     L2Addr_DO,
   output logic                                              L2Rd_SO,
   input  logic [AW-PG_BITS-1:0]                             L2RdVpn_DI,
   input  logic                                              L2RdValid_DI,
   output logic                                              L2ClrValid_SO,
`ifdef RAB_INV_HIT_CNT_EN
   output logic [15:0]                                       InvCnt_DO,
`endif
   output logic                                              Busy_SO
);

   localparam int unsigned N_ENTRIES = L2_N_SETS * L2_N_SET_ENTRIES;
   localparam int unsigned IW        = $clog2(N_ENTRIES);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_ENTRIES - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_L1, S_L2_RD, S_L2_CMP, S_RESP} state_t;

   state_t          state_q, state_d;
   logic            aw_held_q, w_held_q;
   logic [7:0]      awaddr_q;
   logic [AW-1:0]   wdata_q;
   logic [AW-1:0]   lo_q, lo_d, hi_q, hi_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [1:0]      bresp_q, bresp_d;
   logic            exec;
   logic            aw_rdy, w_rdy;
   logic            unused_addr;

   assign unused_addr = ^AwAddr_DI[AW-1:8];

   // Readies are masked during reset so every output reads 0 while Rst_RI is high.
   assign aw_rdy     = !Rst_RI && (state_q == S_IDLE) && !aw_held_q;
   assign w_rdy      = !Rst_RI && (state_q == S_IDLE) && !w_held_q;
   assign AwReady_SO = aw_rdy;
   assign WReady_SO  = w_rdy;
   assign BResp_DO   = (state_q == S_RESP) ? bresp_q : 2'b00;
   assign L2Addr_DO  = idx_q;
   assign Busy_SO    = (state_q != S_IDLE);

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         state_q   <= S_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         idx_q     <= '0;
         bresp_q   <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         idx_q   <= idx_d;
         bresp_q <= bresp_d;
         if (exec) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end else begin
            if (AwValid_SI && aw_rdy) begin
               aw_held_q <= 1'b1;
               awaddr_q  <= AwAddr_DI[7:0];
            end
            if (WValid_SI && w_rdy) begin
               w_held_q <= 1'b1;
               wdata_q  <= WData_DI;
            end
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      lo_d          = lo_q;
      hi_d          = hi_q;
      idx_d         = idx_q;
      bresp_d       = bresp_q;
      exec          = 1'b0;
      L1Inv_SO      = '0;
      L2Rd_SO       = 1'b0;
      L2ClrValid_SO = 1'b0;
      BValid_SO     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (aw_held_q && w_held_q) begin
               exec    = 1'b1;
               bresp_d = RESP_OKAY;
               idx_d   = '0;
               case (awaddr_q)
                  8'h10: begin
                     lo_d    = wdata_q;
                     state_d = S_RESP;
                  end
                  8'h18: begin
                     hi_d = wdata_q;
                     if (wdata_q < lo_q) begin
                        bresp_d = RESP_SLVERR;
                        state_d = S_RESP;
                     end else begin
                        state_d = S_L1;
                     end
                  end
                  default: state_d = S_RESP;
               endcase
            end
         end
         S_L1: begin
            for (int unsigned i = 0; i < N_SLICES; i++) begin
               L1Inv_SO[i] = (L1First_DI[i*AW +: AW] <= hi_q) && (L1Last_DI[i*AW +: AW] >= lo_q);
            end
            state_d = S_L2_RD;
         end
         S_L2_RD: begin
            L2Rd_SO = 1'b1;
            state_d = S_L2_CMP;
         end
         S_L2_CMP: begin
            L2ClrValid_SO = L2RdValid_DI
                            && (L2RdVpn_DI >= lo_q[AW-1:PG_BITS])
                            && (L2RdVpn_DI <= hi_q[AW-1:PG_BITS]);
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_RESP;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_L2_RD;
            end
         end
         S_RESP: begin
            BValid_SO = 1'b1;
            if (BReady_SI) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef RAB_INV_HIT_CNT_EN
   logic [15:0] cnt_q, cnt_add;
   logic [16:0] cnt_sum;

   always_comb begin
      cnt_add = 16'(L2ClrValid_SO);
      for (int unsigned i = 0; i < N_SLICES; i++) begin
         cnt_add = cnt_add + 16'(L1Inv_SO[i]);
      end
      cnt_sum = 17'(cnt_q) + 17'(cnt_add);
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) cnt_q <= '0;
      else        cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   assign InvCnt_DO = cnt_q;
`endif

endmodule

// File: tb/tb_rab_inv_range_ctrl.sv
// Directed, table-driven bench for rab_inv_range_ctrl (32x32 L2, 16 slices).
module tb_rab_inv_range_ctrl;
   localparam int AW = 32;
   localparam int NS = 16;
   localparam int NE = 1024;
   localparam int IW = 10;
   localparam int PG = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [AW-1:0] awaddr = '0, wdata = '0;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic awready, wready, bvalid, l2rd, l2clr, busy;
   logic [1:0] bresp;
   logic [NS*AW-1:0] l1first, l1last;
   logic [NS-1:0] l1inv;
   logic [IW-1:0] l2addr;
   logic [AW-PG-1:0] rdvpn = '0;
   logic rdvalid = 1'b0;
   logic [AW-PG-1:0] mem_vpn [NE];
   logic mem_valid [NE];
`ifdef RAB_INV_HIT_CNT_EN
   logic [15:0] invcnt;
`endif

   rab_inv_range_ctrl #(.AW(AW), .N_SLICES(NS), .L2_N_SETS(32), .L2_N_SET_ENTRIES(32), .PG_BITS(PG)) dut (
      .Clk_CI(clk), .Rst_RI(rst),
      .AwAddr_DI(awaddr), .AwValid_SI(awvalid), .AwReady_SO(awready),
      .WData_DI(wdata), .WValid_SI(wvalid), .WReady_SO(wready),
      .BResp_DO(bresp), .BValid_SO(bvalid), .BReady_SI(bready),
      .L1First_DI(l1first), .L1Last_DI(l1last), .L1Inv_SO(l1inv),
      .L2Addr_DO(l2addr), .L2Rd_SO(l2rd), .L2RdVpn_DI(rdvpn), .L2RdValid_DI(rdvalid),
      .L2ClrValid_SO(l2clr),
`ifdef RAB_INV_HIT_CNT_EN
      .InvCnt_DO(invcnt),
`endif
      .Busy_SO(busy)
   );

   always #5 clk = ~clk;

   // L2 RAM model: read data one cycle after L2Rd.
   always @(posedge clk) begin
      rdvpn   <= mem_vpn[l2addr];
      rdvalid <= mem_valid[l2addr];
   end

   int checks = 0, errors = 0;
   int cyc = 0;
   int l1_cycles, clr_cnt, clr_addr, rd_cnt, first_rd_cyc, b_cyc;
   logic [NS-1:0] l1_mask;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (l1inv != '0) begin l1_cycles++; l1_mask |= l1inv; end
         if (l2clr) begin clr_cnt++; clr_addr = int'(l2addr); end
         if (l2rd) begin if (rd_cnt == 0) first_rd_cyc = cyc; rd_cnt++; end
         if (bvalid && b_cyc < 0) b_cyc = cyc;
      end
   end

   task automatic clear_mon();
      l1_cycles = 0; l1_mask = '0; clr_cnt = 0; clr_addr = -1;
      rd_cnt = 0; first_rd_cyc = -1; b_cyc = -1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   task automatic send_w(input logic [AW-1:0] d);
      int n = 0;
      @(negedge clk); wdata = d; wvalid = 1'b1;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (!wready) begin tmo("w_accept"); wvalid = 1'b0; return; end
      @(posedge clk); #1; wvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [AW-1:0] a);
      int n = 0;
      @(negedge clk); awaddr = a; awvalid = 1'b1;
      while (!awready && n < 100) begin @(negedge clk); n++; end
      if (!awready) begin tmo("aw_accept"); awvalid = 1'b0; return; end
      @(posedge clk); #1; awvalid = 1'b0;
   endtask

   task automatic wait_b(input string name, input logic [1:0] exp, input int hold);
      int n = 0;
      while (!bvalid && n < 4000) begin @(negedge clk); n++; end
      if (!bvalid) begin tmo({name, "_bvalid"}); return; end
      chk({name, "_bresp"}, 64'(bresp), 64'(exp));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk($sformatf("%s_hold%0d", name, k), {61'd0, bvalid, bresp}, {61'd0, 1'b1, exp});
      end
      bready = 1'b1;
      @(posedge clk); #1; bready = 1'b0;
   endtask

   task automatic cmd(input string name, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                      input logic [1:0] exp);
      send_w(lo); send_aw(32'h10); wait_b({name, "_lo"}, 2'b00, 0);
      clear_mon();
      send_w(hi); send_aw(32'h18); wait_b(name, exp, 0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({awready, wready, bresp, bvalid, l1inv, l2addr, l2rd, l2clr, busy});
   endfunction

   typedef struct {
      logic [AW-1:0] lo, hi;
      logic [NS-1:0] exp_l1;
      int            exp_clr, exp_addr;
      logic [1:0]    exp_resp;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{32'h10000, 32'h10FFF, 16'h0008, 0, -1,   2'b00};
      vecs[1] = '{32'h20000, 32'h20FFF, 16'h0000, 1, 5,    2'b00};
      vecs[2] = '{32'h05000, 32'h04000, 16'h0000, 0, -1,   2'b10};
      vecs[3] = '{32'h30FFF, 32'h30FFF, 16'h0080, 1, 1023, 2'b00};
      vecs[4] = '{32'h2F000, 32'h30000, 16'h0080, 1, 1023, 2'b00};
      vecs[5] = '{32'h31000, 32'h31000, 16'h0000, 0, -1,   2'b00};
      vecs[6] = '{32'h40000, 32'h40000, 16'h0000, 1, 0,    2'b00};

      for (int i = 0; i < NS; i++) begin
         l1first[i*AW +: AW] = 32'h100000 + 32'(i) * 32'h1000;
         l1last[i*AW +: AW]  = 32'h100FFF + 32'(i) * 32'h1000;
      end
      l1first[3*AW +: AW] = 32'h10000; l1last[3*AW +: AW] = 32'h10FFF;
      l1first[7*AW +: AW] = 32'h30000; l1last[7*AW +: AW] = 32'h30FFF;
      for (int e = 0; e < NE; e++) begin mem_vpn[e] = '0; mem_valid[e] = 1'b0; end
      mem_vpn[5] = 20'h20;    mem_valid[5] = 1'b1;
      mem_vpn[6] = 20'h21;    mem_valid[6] = 1'b1;
      mem_vpn[9] = 20'h20;    mem_valid[9] = 1'b0;
      mem_vpn[1023] = 20'h30; mem_valid[1023] = 1'b1;
      mem_vpn[0] = 20'h40;    mem_valid[0] = 1'b1;
      clear_mon();

      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs(), 64'd0);
`ifdef RAB_INV_HIT_CNT_EN
      chk("reset_cnt", 64'(invcnt), 64'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {62'd0, awready, wready}, 64'd3);

      for (int i = 0; i < 7; i++) begin
         cmd($sformatf("v%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].exp_resp);
         chk($sformatf("v%0d_l1mask", i), 64'(l1_mask), 64'(vecs[i].exp_l1));
         chk($sformatf("v%0d_l1cyc", i), 64'(l1_cycles), (vecs[i].exp_l1 != '0) ? 64'd1 : 64'd0);
         chk($sformatf("v%0d_clrcnt", i), 64'(clr_cnt), 64'(vecs[i].exp_clr));
         if (vecs[i].exp_clr > 0)
            chk($sformatf("v%0d_clraddr", i), 64'(clr_addr), 64'(vecs[i].exp_addr));
         if (vecs[i].exp_resp == 2'b00) begin
            chk($sformatf("v%0d_rdcnt", i), 64'(rd_cnt), 64'd1024);
            chk($sformatf("v%0d_latency", i), 64'(1 + b_cyc - first_rd_cyc), 64'd2049);
         end else begin
            chk($sformatf("v%0d_rdcnt", i), 64'(rd_cnt), 64'd0);
         end
`ifdef RAB_INV_HIT_CNT_EN
         if (i == 1) chk("hitcnt_after_1_2", 64'(invcnt), 64'd2);
`endif
      end

      // no-op address: OKAY and no sweep
      clear_mon();
      send_w(32'hDEAD); send_aw(32'h20); wait_b("noop", 2'b00, 0);
      repeat (2) @(negedge clk);
      chk("noop_rdcnt", 64'(rd_cnt), 64'd0);

      // W three cycles ahead of AW, BReady withheld 10 cycles
      send_w(32'h20000); send_aw(32'h10); wait_b("t4_lo", 2'b00, 0);
      clear_mon();
      send_w(32'h20FFF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t4_wait%0d", k), {60'd0, busy, wready, awready, l2rd}, {60'd0, 4'b0010});
      end
      send_aw(32'h18);
      wait_b("t4", 2'b00, 10);
      chk("t4_clrcnt", 64'(clr_cnt), 64'd1);
      chk("t4_clraddr", 64'(clr_addr), 64'd5);

      // reset mid-sweep at idx 100
      send_w(32'h0); send_aw(32'h10); wait_b("t5_lo", 2'b00, 0);
      send_w(32'hFFFFFFFF); send_aw(32'h18);
      begin
         int n = 0;
         while (!(l2rd && l2addr == 10'd100) && n < 3000) begin @(negedge clk); n++; end
         if (!(l2rd && l2addr == 10'd100)) tmo("t5_idx100");
      end
      rst = 1'b1;
      #1;
      chk("t5_rst_outs", all_outs(), 64'd0);
      @(negedge clk);
      chk("t5_rst_outs2", all_outs(), 64'd0);
      rst = 1'b0;
      clear_mon();
      repeat (2200) @(negedge clk);
      chk("t5_no_b", 64'(b_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t5_no_clr", 64'(clr_cnt), 64'd0);
      cmd("t5_after", 32'h20000, 32'h20FFF, 2'b00);
      chk("t5_after_clr", 64'(clr_cnt), 64'd1);
      chk("t5_after_addr", 64'(clr_addr), 64'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
